// File: rtl/multicycle_ctrl_pkg.sv
// multicycle_ctrl_pkg: opcode/funct constants, ALU encodings and state/class enums
package multicycle_ctrl_pkg;

    typedef enum logic [2:0] {S_IDLE, S_DECODE, S_EXEC, S_MEM, S_WB} state_t;
    typedef enum logic [2:0] {C_RTYPE, C_ALUI, C_LW, C_SW, C_BEQ, C_BNE} cls_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;

    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_XOR = 6'b100110;
    localparam logic [5:0] F_SLT = 6'b101010;
    localparam logic [5:0] F_SLL = 6'b000000;
    localparam logic [5:0] F_SRL = 6'b000010;

    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_XOR = 4'b0100;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_SLL = 4'b1000;
    localparam logic [3:0] ALU_SRL = 4'b1001;

endpackage

// File: rtl/multicycle_ctrl_alu_decode.sv
// alu_decode: combinational opcode/funct to ALU select, B source, class and illegal flag
module alu_decode
    import multicycle_ctrl_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output logic [3:0] alu_ctr,
    output logic       alu_src,
    output cls_t       cls,
    output logic       illegal
);

    always_comb begin
        alu_ctr = ALU_ADD;
        alu_src = 1'b1;
        cls     = C_ALUI;
        illegal = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                alu_src = 1'b0;
                cls     = C_RTYPE;
                case (funct)
                    F_ADD:   alu_ctr = ALU_ADD;
                    F_SUB:   alu_ctr = ALU_SUB;
                    F_AND:   alu_ctr = ALU_AND;
                    F_OR:    alu_ctr = ALU_OR;
                    F_XOR:   alu_ctr = ALU_XOR;
                    F_SLT:   alu_ctr = ALU_SLT;
                    F_SLL:   alu_ctr = ALU_SLL;
                    F_SRL:   alu_ctr = ALU_SRL;
                    default: illegal = 1'b1;
                endcase
            end
            OP_ADDI: alu_ctr = ALU_ADD;
            OP_ANDI: alu_ctr = ALU_AND;
            OP_ORI:  alu_ctr = ALU_OR;
            OP_XORI: alu_ctr = ALU_XOR;
            OP_SLTI: alu_ctr = ALU_SLT;
            OP_LW:   cls = C_LW;
            OP_SW:   cls = C_SW;
            OP_BEQ: begin
                alu_ctr = ALU_SUB;
                alu_src = 1'b0;
                cls     = C_BEQ;
            end
            OP_BNE: begin
                alu_ctr = ALU_SUB;
                alu_src = 1'b0;
                cls     = C_BNE;
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: IDLE/DECODE/EXEC/MEM/WB instruction controller with registered strobes
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       instr_valid,
    output logic       instr_ready,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       Zero,
    input  logic       mem_ready,
    output logic [3:0] ALUctr,
    output logic       ALUsrc,
    output logic       RegWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       done,
    output logic       branch_taken,
    output logic       err
);

    localparam logic [7:0] LAST = 8'(MEM_TIMEOUT - 1);

    state_t     state;
    cls_t       cls_q;
    logic [5:0] op_q, fn_q;
    logic [7:0] cnt;
    logic [3:0] d_ctr;
    logic       d_src, d_ill;
    cls_t       d_cls;

    alu_decode u_dec (
        .opcode (op_q),
        .funct  (fn_q),
        .alu_ctr(d_ctr),
        .alu_src(d_src),
        .cls    (d_cls),
        .illegal(d_ill)
    );

    // Pulses and per-state strobes default low; each state re-asserts what it owns.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            cls_q        <= C_RTYPE;
            op_q         <= '0;
            fn_q         <= '0;
            cnt          <= '0;
            instr_ready  <= 1'b1;
            ALUctr       <= '0;
            ALUsrc       <= 1'b0;
            RegWrite     <= 1'b0;
            RegDst       <= 1'b0;
            MemtoReg     <= 1'b0;
            MemRead      <= 1'b0;
            MemWrite     <= 1'b0;
            done         <= 1'b0;
            branch_taken <= 1'b0;
            err          <= 1'b0;
        end else begin
            RegWrite     <= 1'b0;
            RegDst       <= 1'b0;
            MemtoReg     <= 1'b0;
            MemRead      <= 1'b0;
            MemWrite     <= 1'b0;
            done         <= 1'b0;
            branch_taken <= 1'b0;
            err          <= 1'b0;
            case (state)
                S_IDLE: if (instr_valid) begin
                    op_q        <= opcode;
                    fn_q        <= funct;
                    state       <= S_DECODE;
                    instr_ready <= 1'b0;
                end
                S_DECODE: if (d_ill) begin
                    err         <= 1'b1;
                    state       <= S_IDLE;
                    instr_ready <= 1'b1;
                end else begin
                    ALUctr <= d_ctr;
                    ALUsrc <= d_src;
                    cls_q  <= d_cls;
                    state  <= S_EXEC;
                end
                S_EXEC: if (cls_q == C_BEQ || cls_q == C_BNE) begin
                    done         <= 1'b1;
                    branch_taken <= (cls_q == C_BEQ) ? Zero : !Zero;
                    state        <= S_IDLE;
                    instr_ready  <= 1'b1;
                    ALUctr       <= '0;
                    ALUsrc       <= 1'b0;
                end else if (cls_q == C_LW || cls_q == C_SW) begin
                    state    <= S_MEM;
                    cnt      <= '0;
                    MemRead  <= cls_q == C_LW;
                    MemWrite <= cls_q == C_SW;
                end else begin
                    state    <= S_WB;
                    RegWrite <= 1'b1;
                    RegDst   <= cls_q == C_RTYPE;
                end
                // mem_ready is checked before the timeout so a late completion still wins
                S_MEM: if (mem_ready) begin
                    if (cls_q == C_LW) begin
                        state    <= S_WB;
                        RegWrite <= 1'b1;
                        MemtoReg <= 1'b1;
                    end else begin
                        done        <= 1'b1;
                        state       <= S_IDLE;
                        instr_ready <= 1'b1;
                        ALUctr      <= '0;
                        ALUsrc      <= 1'b0;
                    end
                end else if (cnt == LAST) begin
                    err         <= 1'b1;
                    state       <= S_IDLE;
                    instr_ready <= 1'b1;
                    ALUctr      <= '0;
                    ALUsrc      <= 1'b0;
                end else begin
                    cnt      <= cnt + 8'd1;
                    MemRead  <= cls_q == C_LW;
                    MemWrite <= cls_q == C_SW;
                end
                S_WB: begin
                    done        <= 1'b1;
                    state       <= S_IDLE;
                    instr_ready <= 1'b1;
                    ALUctr      <= '0;
                    ALUsrc      <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: table-driven vectors plus memory, timeout and reset sequences
module tb_multicycle_ctrl;

    logic       clk = 1'b0, reset = 1'b1, instr_valid = 1'b0, Zero = 1'b0, mem_ready = 1'b0;
    logic [5:0] opcode = '0, funct = '0;
    logic       instr_ready, ALUsrc, RegWrite, RegDst, MemtoReg, MemRead, MemWrite;
    logic       done, branch_taken, err;
    logic [3:0] ALUctr;

    always #5 clk = ~clk;

    multicycle_ctrl #(.MEM_TIMEOUT(15)) dut (
        .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .opcode(opcode), .funct(funct), .Zero(Zero), .mem_ready(mem_ready),
        .ALUctr(ALUctr), .ALUsrc(ALUsrc), .RegWrite(RegWrite), .RegDst(RegDst),
        .MemtoReg(MemtoReg), .MemRead(MemRead), .MemWrite(MemWrite),
        .done(done), .branch_taken(branch_taken), .err(err)
    );

    typedef struct packed {
        logic [3:0] ctr;
        logic src, rdy, rw, rd, m2r, mr, mw, dn, bt, er;
    } snap_t;

    typedef struct {
        logic [5:0] op, fn;
        logic       z;
        logic [3:0] ctr;
        logic       src;
        int         kind;
        logic       rd, bt;
    } vec_t;

    localparam int IDLE_SNAP = 'h100;

    snap_t sn [0:31];
    vec_t  v [0:18];
    int    errors = 0, checks = 0;
    int    done_at, err_at, done_n, mr_n, mw_n;

    function automatic snap_t grab();
        return {ALUctr, ALUsrc, instr_ready, RegWrite, RegDst, MemtoReg, MemRead, MemWrite,
                done, branch_taken, err};
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_idle();
        int k = 0;
        @(negedge clk);
        while (!instr_ready && k < 60) begin
            @(negedge clk);
            k++;
        end
        if (!instr_ready) chk("idle_timeout", 0, 1);
    endtask

    // Handshake, then sample cycles 1..ncyc; mem_ready pulses only in cycle rdy_at.
    // noise adds mem_ready in cycles 1-2 and an illegal instr_valid in cycles 1-5.
    task automatic run(input logic [5:0] op, input logic [5:0] fn, input logic z,
                       input int ncyc, input int rdy_at, input bit noise);
        wait_idle();
        instr_valid = 1'b1;
        opcode = op;
        funct = fn;
        Zero = z;
        mem_ready = 1'b0;
        @(posedge clk);
        #1;
        instr_valid = noise;
        opcode = noise ? 6'h3f : op;
        mem_ready = noise;
        done_at = 0; err_at = 0; done_n = 0; mr_n = 0; mw_n = 0;
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clk);
            sn[c] = grab();
            if (sn[c].dn && done_at == 0) done_at = c;
            if (sn[c].er && err_at == 0) err_at = c;
            done_n += int'(sn[c].dn);
            mr_n += int'(sn[c].mr);
            mw_n += int'(sn[c].mw);
            mem_ready = (c == rdy_at) || (noise && c < 2);
            instr_valid = noise && c < 5;
        end
        mem_ready = 1'b0;
        instr_valid = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int pend;
        snap_t s;
        // kind: 0 ALU op, 1 branch, 2 illegal
        v[0]  = '{6'b000000, 6'b100000, 1'b0, 4'b0010, 1'b0, 0, 1'b1, 1'b0};
        v[1]  = '{6'b000000, 6'b100010, 1'b0, 4'b0110, 1'b0, 0, 1'b1, 1'b0};
        v[2]  = '{6'b000000, 6'b100100, 1'b0, 4'b0000, 1'b0, 0, 1'b1, 1'b0};
        v[3]  = '{6'b000000, 6'b100101, 1'b0, 4'b0001, 1'b0, 0, 1'b1, 1'b0};
        v[4]  = '{6'b000000, 6'b100110, 1'b0, 4'b0100, 1'b0, 0, 1'b1, 1'b0};
        v[5]  = '{6'b000000, 6'b101010, 1'b0, 4'b0111, 1'b0, 0, 1'b1, 1'b0};
        v[6]  = '{6'b000000, 6'b000000, 1'b0, 4'b1000, 1'b0, 0, 1'b1, 1'b0};
        v[7]  = '{6'b000000, 6'b000010, 1'b0, 4'b1001, 1'b0, 0, 1'b1, 1'b0};
        v[8]  = '{6'b001000, 6'b010101, 1'b0, 4'b0010, 1'b1, 0, 1'b0, 1'b0};
        v[9]  = '{6'b001100, 6'b000000, 1'b0, 4'b0000, 1'b1, 0, 1'b0, 1'b0};
        v[10] = '{6'b001101, 6'b000000, 1'b0, 4'b0001, 1'b1, 0, 1'b0, 1'b0};
        v[11] = '{6'b001110, 6'b000000, 1'b0, 4'b0100, 1'b1, 0, 1'b0, 1'b0};
        v[12] = '{6'b001010, 6'b000000, 1'b0, 4'b0111, 1'b1, 0, 1'b0, 1'b0};
        v[13] = '{6'b000100, 6'b000000, 1'b1, 4'b0110, 1'b0, 1, 1'b0, 1'b1};
        v[14] = '{6'b000100, 6'b000000, 1'b0, 4'b0110, 1'b0, 1, 1'b0, 1'b0};
        v[15] = '{6'b000101, 6'b000000, 1'b1, 4'b0110, 1'b0, 1, 1'b0, 1'b0};
        v[16] = '{6'b000101, 6'b000000, 1'b0, 4'b0110, 1'b0, 1, 1'b0, 1'b1};
        v[17] = '{6'b111111, 6'b000000, 1'b0, 4'b0000, 1'b0, 2, 1'b0, 1'b0};
        v[18] = '{6'b000000, 6'b111111, 1'b0, 4'b0000, 1'b0, 2, 1'b0, 1'b0};

        repeat (3) @(negedge clk);
        chk("reset_state", int'(grab()), IDLE_SNAP);
        reset = 1'b0;

        for (int i = 0; i < 19; i++) begin
            run(v[i].op, v[i].fn, v[i].z, 5, 0, 1'b0);
            chk($sformatf("v%0d_ctr", i), int'(sn[2].ctr), int'(v[i].ctr));
            chk($sformatf("v%0d_src", i), int'(sn[2].src), int'(v[i].src));
            chk($sformatf("v%0d_done_at", i), done_at, v[i].kind == 0 ? 4 : v[i].kind == 1 ? 3 : 0);
            chk($sformatf("v%0d_err_at", i), err_at, v[i].kind == 2 ? 2 : 0);
            chk($sformatf("v%0d_regwrite", i), int'(sn[3].rw), int'(v[i].kind == 0));
            chk($sformatf("v%0d_regdst", i), int'(sn[3].rd), int'(v[i].rd));
            chk($sformatf("v%0d_taken", i), int'(sn[3].bt), int'(v[i].bt));
            chk($sformatf("v%0d_ctr_clr", i), int'(sn[5].ctr), 0);
        end

        run(6'b100011, 6'b000000, 1'b0, 8, 5, 1'b1);
        chk("lw_ctr", int'(sn[2].ctr), 2);
        chk("lw_src", int'(sn[2].src), 1);
        chk("lw_memread_n", mr_n, 3);
        chk("lw_memread_c3", int'(sn[3].mr), 1);
        chk("lw_memread_c5", int'(sn[5].mr), 1);
        chk("lw_wb_regwrite", int'(sn[6].rw), 1);
        chk("lw_wb_memtoreg", int'(sn[6].m2r), 1);
        chk("lw_wb_regdst", int'(sn[6].rd), 0);
        chk("lw_wb_memread", int'(sn[6].mr), 0);
        chk("lw_done_at", done_at, 7);
        chk("lw_done_n", done_n, 1);
        chk("lw_err_at", err_at, 0);

        run(6'b101011, 6'b000000, 1'b0, 20, 0, 1'b0);
        chk("sw_to_memwrite_n", mw_n, 15);
        chk("sw_to_memwrite_c17", int'(sn[17].mw), 1);
        chk("sw_to_err_at", err_at, 18);
        chk("sw_to_done_at", done_at, 0);
        chk("sw_to_memwrite_c18", int'(sn[18].mw), 0);
        chk("sw_to_ready_c18", int'(sn[18].rdy), 1);
        chk("sw_to_ctr_c18", int'(sn[18].ctr), 0);

        run(6'b101011, 6'b000000, 1'b0, 20, 17, 1'b0);
        chk("sw_edge_done_at", done_at, 18);
        chk("sw_edge_err_at", err_at, 0);
        chk("sw_edge_memwrite_n", mw_n, 15);

        run(6'b101011, 6'b000000, 1'b0, 6, 3, 1'b0);
        chk("sw_n1_done_at", done_at, 4);
        chk("sw_n1_memwrite_n", mw_n, 1);

        wait_idle();
        instr_valid = 1'b1;
        opcode = 6'b100011;
        funct = 6'b000000;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("midrst_in_mem", int'(MemRead), 1);
        reset = 1'b1;
        mem_ready = 1'b1;
        @(negedge clk);
        chk("midrst_state", int'(grab()), IDLE_SNAP);
        reset = 1'b0;
        mem_ready = 1'b0;
        pend = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            s = grab();
            pend += int'(s.dn) + int'(s.er);
        end
        chk("midrst_no_pulse", pend, 0);

        run(6'b000000, 6'b100000, 1'b0, 5, 0, 1'b0);
        chk("recover_done_at", done_at, 4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
